// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: sequences one ALU operation at a time over an 8-bit register file.
// A request reads its two operands, drives them to the external ALU, waits ALU_LAT
// cycles, then writes the 8- or 16-bit result back and updates the {C,Z,N} flags.
module alu_op_sequencer #(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned NREG    = 8,
  localparam int unsigned AW     = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [7:0]    req_op,
  input  logic [AW-1:0] req_rd,
  input  logic [AW-1:0] req_rr,
  input  logic          req_wide,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [7:0]    dbg_data,
  output logic [2:0]    flags,
  output logic          busy,
  output logic          done,
  output logic [7:0]    alu_rr,
  output logic [7:0]    alu_rd,
  output logic          alu_ci,
  output logic [7:0]    alu_op,
  input  logic [15:0]   alu_data,
  input  logic          alu_co,
  input  logic          alu_zo,
  input  logic          alu_no
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t        state;
  logic [7:0]    regs [NREG];
  logic [CW-1:0] cnt;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rd_nxt;
  logic          wide_q;
  logic [15:0]   res_q;
  logic [2:0]    st_q;

  // Loads take priority over requests; nothing is accepted while an op is in flight.
  assign req_ready = (state == S_IDLE) && !ld_valid;
  assign busy      = (state != S_IDLE);
  assign dbg_data  = regs[dbg_addr];
  // Upper-byte destination wraps naturally at AW bits.
  assign rd_nxt    = rd_q + AW'(1);

  // Sequencer FSM, register file and all registered outputs.
  // ALU inputs are launched on the accepting edge so they are already stable during ISSUE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= 8'h00;
      flags  <= 3'b000;
      done   <= 1'b0;
      alu_rr <= 8'h00;
      alu_rd <= 8'h00;
      alu_ci <= 1'b0;
      alu_op <= 8'h00;
      cnt    <= '0;
      rd_q   <= '0;
      wide_q <= 1'b0;
      res_q  <= 16'h0000;
      st_q   <= 3'b000;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ld_valid) begin
            regs[ld_addr] <= ld_data;
          end else if (req_valid) begin
            alu_rd <= regs[req_rd];
            alu_rr <= regs[req_rr];
            alu_op <= req_op;
            alu_ci <= flags[2];
            rd_q   <= req_rd;
            wide_q <= req_wide;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= CW'(ALU_LAT - 1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == '0) begin
            res_q <= alu_data;
            st_q  <= {alu_co, alu_zo, alu_no};
            state <= S_WB;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_WB: begin
          regs[rd_q] <= res_q[7:0];
          if (wide_q) regs[rd_nxt] <= res_q[15:8];
          flags <= st_q;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (ALU_LAT=1 and 3), each with its own ALU
// model, reference register-file model and done-driven scoreboard.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned      cyc;
    logic [2:0]       flags;
    logic [7:0][7:0]  regs;
  } exp_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ALU behaviour: op 01 add with carry-in, op 02 multiply; flags from the result.
  function automatic logic [18:0] alu_f(input logic [7:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic ci);
    logic [15:0] r;
    r = 16'h0000;
    if (op == 8'h01) r = 16'(a) + 16'(b) + 16'(ci);
    else if (op == 8'h02) r = 16'(a) * 16'(b);
    return {r[8], (r[7:0] == 8'h00), r[7], r};
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int unsigned LAT = (gi == 0) ? 1 : 3;

    logic        rst, req_valid, req_ready, req_wide, ld_valid, busy, done;
    logic        alu_ci, alu_co, alu_zo, alu_no;
    logic [7:0]  req_op, ld_data, dbg_data, alu_rr, alu_rd, alu_op;
    logic [2:0]  req_rd, req_rr, ld_addr, dbg_addr, flags;
    logic [15:0] alu_data;
    logic        fin = 1'b0;

    exp_t        q[$];
    logic [7:0]  mregs [8];
    logic [2:0]  mflags;
    logic        prev_done;

    alu_op_sequencer #(.ALU_LAT(LAT), .NREG(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_rd(req_rd), .req_rr(req_rr), .req_wide(req_wide),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .flags(flags), .busy(busy), .done(done),
      .alu_rr(alu_rr), .alu_rd(alu_rd), .alu_ci(alu_ci), .alu_op(alu_op),
      .alu_data(alu_data), .alu_co(alu_co), .alu_zo(alu_zo), .alu_no(alu_no)
    );

    // External ALU: registered, LAT stages deep.
    logic [18:0] pipe [LAT];
    always @(posedge clk) begin
      pipe[0] <= alu_f(alu_op, alu_rd, alu_rr, alu_ci);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign {alu_co, alu_zo, alu_no, alu_data} = pipe[LAT-1];

    function automatic string nm(input string s);
      return $sformatf("L%0d_%s", LAT, s);
    endfunction

    task automatic model_reset();
      for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
      mflags = 3'b000;
    endtask

    task automatic do_load(input logic [2:0] a, input logic [7:0] d);
      ld_valid = 1'b1; ld_addr = a; ld_data = d;
      @(posedge clk); #1;
      ld_valid = 1'b0;
      mregs[a] = d;
    endtask

    // Request one op; optionally collide with a load, optionally fire an ignored load while busy.
    task automatic issue(input logic [7:0] op, input logic [2:0] rd, input logic [2:0] rr,
                         input logic wide, input logic contend, input logic drop);
      exp_t        e;
      logic [18:0] r;
      logic [7:0]  a, b;
      logic        ci;
      logic [2:0]  rd1;
      req_valid = 1'b1; req_op = op; req_rd = rd; req_rr = rr; req_wide = wide;
      if (contend) begin
        ld_valid = 1'b1; ld_addr = rr; ld_data = 8'($urandom);
        @(negedge clk);
        chk(nm("ready_contend"), req_ready, 0);
        @(posedge clk); #1;
        mregs[ld_addr] = ld_data;
        ld_valid = 1'b0;
      end
      @(negedge clk);
      chk(nm("ready_idle"), req_ready, 1);
      a  = mregs[rd];
      b  = mregs[rr];
      ci = mflags[2];
      r  = alu_f(op, a, b, ci);
      rd1 = rd + 3'd1;
      mregs[rd] = r[7:0];
      if (wide) mregs[rd1] = r[15:8];
      mflags = r[18:16];
      e.cyc   = cyc + 1 + LAT + 2;
      e.flags = mflags;
      for (int i = 0; i < 8; i++) e.regs[i] = mregs[i];
      q.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0; req_op = 8'($urandom); req_rd = 3'($urandom); req_rr = 3'($urandom);
      if (drop) begin
        ld_valid = 1'b1; ld_addr = rd + 3'd2; ld_data = ~r[7:0];
      end
      @(negedge clk);
      chk(nm("busy_issue"), busy, 1);
      chk(nm("ready_busy"), req_ready, 0);
      chk(nm("alu_ci"), alu_ci, ci);
      chk(nm("alu_rd"), alu_rd, a);
      chk(nm("alu_rr"), alu_rr, b);
      chk(nm("alu_op"), alu_op, op);
      @(posedge clk); #1;
      ld_valid = 1'b0;
    endtask

    task automatic wait_idle();
      int k;
      k = 0;
      while (q.size() != 0 && k < 64) begin
        @(posedge clk);
        k++;
      end
      chk(nm("done_seen"), q.size(), 0);
      q.delete();
      #1;
    endtask

    // Scoreboard monitor: on each done pulse pop the expected outcome and compare.
    initial begin
      exp_t e;
      dbg_addr  = 3'd0;
      prev_done = 1'b0;
      forever begin
        @(negedge clk);
        if (done === 1'b1) begin
          chk(nm("done_pulse"), prev_done, 0);
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: done with no op outstanding at cycle %0d", nm("spurious_done"), cyc);
          end else begin
            e = q.pop_front();
            chk(nm("latency"), cyc, e.cyc);
            chk(nm("flags"), flags, e.flags);
            for (int i = 0; i < 8; i++) begin
              dbg_addr = 3'(i);
              #1;
              chk(nm($sformatf("reg%0d", i)), dbg_data, e.regs[i]);
            end
          end
        end
        prev_done = (done === 1'b1);
      end
    end

    // Stimulus: directed scenarios followed by random traffic.
    initial begin
      rst = 1'b0; req_valid = 1'b0; req_op = 8'h00; req_rd = 3'd0; req_rr = 3'd0;
      req_wide = 1'b0; ld_valid = 1'b0; ld_addr = 3'd0; ld_data = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk(nm("rst_flags"), flags, 3'b000);
      chk(nm("rst_ready"), req_ready, 1);
      chk(nm("rst_busy"), busy, 0);
      chk(nm("rst_done"), done, 0);
      chk(nm("rst_alu_rd"), alu_rd, 8'h00);
      chk(nm("rst_alu_op"), alu_op, 8'h00);
      @(posedge clk); #1;
      rst = 1'b1;

      do_load(3'd1, 8'hF0);
      do_load(3'd2, 8'h20);
      issue(8'h01, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0);
      wait_idle();
      chk(nm("t2_flags"), flags, 3'b100);

      issue(8'h01, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0);
      wait_idle();
      chk(nm("t3_flags"), flags, 3'b000);

      do_load(3'd7, 8'h10);
      do_load(3'd0, 8'h20);
      issue(8'h02, 3'd7, 3'd0, 1'b1, 1'b0, 1'b1);
      wait_idle();
      chk(nm("t4_flags"), flags, 3'b010);

      issue(8'h01, 3'd3, 3'd4, 1'b0, 1'b1, 1'b0);
      wait_idle();

      do_load(3'd5, 8'hAA);
      issue(8'h01, 3'd5, 3'd5, 1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      q.delete();
      model_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk(nm("abort_busy"), busy, 0);
      chk(nm("abort_done"), done, 0);
      chk(nm("abort_flags"), flags, 3'b000);
      repeat (LAT + 4) @(posedge clk);
      #1;
      do_load(3'd6, 8'h7F);
      issue(8'h01, 3'd6, 3'd6, 1'b0, 1'b0, 1'b0);
      wait_idle();

      for (int n = 0; n < 40; n++) begin
        int nl;
        nl = $urandom_range(0, 2);
        for (int j = 0; j < nl; j++) do_load(3'($urandom), 8'($urandom));
        issue(($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02, 3'($urandom), 3'($urandom),
              1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        wait_idle();
      end
      fin = 1'b1;
    end
  end

  // End of run: wait for both instances, bounded.
  initial begin
    for (int k = 0; k < 20000; k++) begin
      @(posedge clk);
      if (g[0].fin && g[1].fin) break;
    end
    if (!(g[0].fin && g[1].fin)) begin
      total++;
      bad++;
      $display("FAIL tb_timeout: fin0=%0d fin1=%0d want both 1", g[0].fin, g[1].fin);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
